// File: rtl/multi_edge_detect_module.sv
// rtl/multi_edge_detect_module.sv - multi-channel synchronising, glitch-filtering edge detector
//
// Purpose:
//   Per channel: a SYNC_STAGES-deep synchroniser, then a level filter that
//   accepts a new level only after it has persisted for FILT_LEN synchronised
//   cycles. Edge pulses come from the filtered level, and a per-channel mode
//   selects which of them are reported. Reported edges set sticky Pending and
//   Overrun flags.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          synchronous active-high reset
//   Pin_In       raw asynchronous pin levels, one per channel
//   Edge_Mode    2 bits per channel: 00 off, 01 falling, 10 rising, 11 both
//   Clr_Pending  per-channel clear of Pending and Overrun
//   Level_Out    filtered, synchronised level
//   H2L_Sig      one-cycle pulse on a filtered high-to-low transition
//   L2H_Sig      one-cycle pulse on a filtered low-to-high transition
//   Edge_Sig     H2L_Sig/L2H_Sig masked by Edge_Mode
//   Pending      sticky flag set by Edge_Sig
//   Overrun      sticky flag set by Edge_Sig while Pending is already set
//   Any_Pending  OR of all Pending bits

module multi_edge_detect_module #(
    parameter int   CH          = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = 4,
    parameter logic INIT_LEVEL  = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [CH-1:0]   Pin_In,
    input  logic [2*CH-1:0] Edge_Mode,
    input  logic [CH-1:0]   Clr_Pending,
    output logic [CH-1:0]   Level_Out,
    output logic [CH-1:0]   H2L_Sig,
    output logic [CH-1:0]   L2H_Sig,
    output logic [CH-1:0]   Edge_Sig,
    output logic [CH-1:0]   Pending,
    output logic [CH-1:0]   Overrun,
    output logic            Any_Pending
);

    // FILT_LEN = 1 still needs a one-bit counter; it simply never leaves 0.
    localparam int               CNT_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    genvar i;
    generate
        for (i = 0; i < CH; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   s;
            logic                   f_q;
            logic                   f_d_q;
            logic [CNT_W-1:0]       cnt_q;
            logic                   h2l;
            logic                   l2h;
            logic                   edge_hit;
            logic                   pend_q;
            logic                   ovr_q;

            assign s = sync_q[SYNC_STAGES-1];

            always_ff @(posedge CLK) begin
                if (RST) begin
                    sync_q <= {SYNC_STAGES{INIT_LEVEL}};
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], Pin_In[i]};
                end
            end

            // cnt_q counts consecutive cycles on which s disagrees with the
            // accepted level; any agreement throws the partial count away.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    f_q   <= INIT_LEVEL;
                    f_d_q <= INIT_LEVEL;
                    cnt_q <= '0;
                end else begin
                    f_d_q <= f_q;
                    if (s == f_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        f_q   <= s;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end

            // Both inputs are flops, so the pulses are glitch-free and last
            // exactly the one cycle during which f_d_q lags f_q.
            assign h2l      = f_d_q & ~f_q;
            assign l2h      = ~f_d_q & f_q;
            assign edge_hit = (Edge_Mode[2*i] & h2l) | (Edge_Mode[2*i+1] & l2h);

            // An edge arriving with a clear wins: Pending stays set and the
            // new Overrun is computed against the cleared state, i.e. 0.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    pend_q <= 1'b0;
                    ovr_q  <= 1'b0;
                end else begin
                    pend_q <= edge_hit | (pend_q & ~Clr_Pending[i]);
                    ovr_q  <= (edge_hit & pend_q & ~Clr_Pending[i]) |
                              (ovr_q & ~Clr_Pending[i]);
                end
            end

            assign Level_Out[i] = f_q;
            assign H2L_Sig[i]   = h2l;
            assign L2H_Sig[i]   = l2h;
            assign Edge_Sig[i]  = edge_hit;
            assign Pending[i]   = pend_q;
            assign Overrun[i]   = ovr_q;
        end
    endgenerate

    assign Any_Pending = |Pending;

endmodule

// File: tb/tb_multi_edge_detect_module.sv
// tb/tb_multi_edge_detect_module.sv - self-checking bench for multi_edge_detect_module

module tb_multi_edge_detect_module;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int FILT = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic [CH-1:0]   Pin_In;
    logic [2*CH-1:0] Edge_Mode;
    logic [CH-1:0]   Clr_Pending;
    logic [CH-1:0]   Level_Out, H2L_Sig, L2H_Sig, Edge_Sig, Pending, Overrun;
    logic            Any_Pending;

    int checks = 0;
    int passes = 0;

    multi_edge_detect_module #(
        .CH(CH), .SYNC_STAGES(SYNC), .FILT_LEN(FILT), .INIT_LEVEL(1'b1)
    ) dut (
        .CLK(CLK), .RST(RST), .Pin_In(Pin_In), .Edge_Mode(Edge_Mode),
        .Clr_Pending(Clr_Pending), .Level_Out(Level_Out), .H2L_Sig(H2L_Sig),
        .L2H_Sig(L2H_Sig), .Edge_Sig(Edge_Sig), .Pending(Pending),
        .Overrun(Overrun), .Any_Pending(Any_Pending)
    );

    always #5 CLK = ~CLK;

    // Reference model: s is the pin value sampled SYNC non-reset edges ago
    // (idle-high until that much history exists); the accepted level flips
    // once s has disagreed with it FILT times in a row.
    logic [CH-1:0] m_f, m_fd, m_pend, m_ovr, m_s, m_e;
    logic [CH-1:0] pin_log[$];
    int            m_run[CH];
    int            since;

    always @(posedge CLK) begin
        if (RST) begin
            m_f = '1; m_fd = '1; m_pend = '0; m_ovr = '0; since = 0;
            for (int c = 0; c < CH; c++) m_run[c] = 0;
        end else begin
            for (int c = 0; c < CH; c++)
                m_e[c] = (Edge_Mode[2*c] & m_fd[c] & ~m_f[c]) | (Edge_Mode[2*c+1] & ~m_fd[c] & m_f[c]);
            m_s = (since >= SYNC) ? pin_log[pin_log.size()-SYNC] : '1;
            pin_log.push_back(Pin_In);
            if (pin_log.size() > 8) void'(pin_log.pop_front());
            if (since < 100) since++;
            m_ovr  = (m_e & m_pend & ~Clr_Pending) | (m_ovr & ~Clr_Pending);
            m_pend = m_e | (m_pend & ~Clr_Pending);
            m_fd   = m_f;
            for (int c = 0; c < CH; c++) begin
                if (m_s[c] == m_f[c]) m_run[c] = 0;
                else begin
                    m_run[c]++;
                    if (m_run[c] == FILT) begin
                        m_f[c]   = m_s[c];
                        m_run[c] = 0;
                    end
                end
            end
        end
    end

    task automatic settle_and_clear();
        Pin_In = '1;
        repeat (12) @(negedge CLK);
        Clr_Pending = '1;
        @(negedge CLK);
        Clr_Pending = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1; Pin_In = '1; Edge_Mode = '0; Clr_Pending = '0;
        repeat (3) @(negedge CLK);
        checks++; if (Level_Out !== 4'hF) $display("FAIL reset_level got=%h exp=f", Level_Out); else passes++;
        checks++; if (H2L_Sig !== 4'h0) $display("FAIL reset_h2l got=%h exp=0", H2L_Sig); else passes++;
        checks++; if (L2H_Sig !== 4'h0) $display("FAIL reset_l2h got=%h exp=0", L2H_Sig); else passes++;
        checks++; if (Edge_Sig !== 4'h0) $display("FAIL reset_edge got=%h exp=0", Edge_Sig); else passes++;
        checks++; if (Pending !== 4'h0) $display("FAIL reset_pending got=%h exp=0", Pending); else passes++;
        checks++; if (Overrun !== 4'h0) $display("FAIL reset_overrun got=%h exp=0", Overrun); else passes++;
        checks++; if (Any_Pending !== 1'b0) $display("FAIL reset_any got=%b exp=0", Any_Pending); else passes++;
        RST = 1'b0;
    endtask

    task automatic test_falling_edge();
        int l2h_seen = 0;
        Edge_Mode = 8'b0000_0001;
        Pin_In[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            checks++; if (Level_Out[0] !== (k < 5)) $display("FAIL fall_level edge=%0d got=%b exp=%b", k, Level_Out[0], k < 5); else passes++;
            checks++; if (H2L_Sig[0] !== (k == 5)) $display("FAIL fall_h2l edge=%0d got=%b exp=%b", k, H2L_Sig[0], k == 5); else passes++;
            checks++; if (Edge_Sig[0] !== (k == 5)) $display("FAIL fall_edge edge=%0d got=%b exp=%b", k, Edge_Sig[0], k == 5); else passes++;
            checks++; if (Pending[0] !== (k >= 6)) $display("FAIL fall_pending edge=%0d got=%b exp=%b", k, Pending[0], k >= 6); else passes++;
            if (L2H_Sig[0]) l2h_seen++;
        end
        checks++; if (l2h_seen != 0) $display("FAIL fall_no_l2h got=%0d exp=0", l2h_seen); else passes++;
        checks++; if (Any_Pending !== 1'b1) $display("FAIL fall_any got=%b exp=1", Any_Pending); else passes++;
        settle_and_clear();
    endtask

    task automatic test_glitch();
        int pulses = 0, dips = 0, t_h2l = -1, t_l2h = -1;
        Edge_Mode = 8'b0000_1100;
        Pin_In[1] = 1'b0;
        repeat (3) @(negedge CLK);
        Pin_In[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (H2L_Sig[1] || L2H_Sig[1]) pulses++;
            if (Level_Out[1] !== 1'b1) dips++;
        end
        checks++; if (pulses != 0) $display("FAIL glitch3_pulses got=%0d exp=0", pulses); else passes++;
        checks++; if (dips != 0) $display("FAIL glitch3_level got=%0d low cycles exp=0", dips); else passes++;
        Pin_In[1] = 1'b0;
        repeat (4) @(negedge CLK);
        Pin_In[1] = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge CLK);
            if (H2L_Sig[1]) t_h2l = k;
            if (L2H_Sig[1]) t_l2h = k;
        end
        checks++; if (t_h2l < 0) $display("FAIL glitch4_h2l got=none exp=pulse"); else passes++;
        checks++; if (t_l2h - t_h2l != 4) $display("FAIL glitch4_spacing got=%0d exp=4", t_l2h - t_h2l); else passes++;
        settle_and_clear();
    endtask

    task automatic test_mode_mask();
        int h2l_n = 0, edge_n = 0;
        Edge_Mode = 8'b0010_0000;
        Pin_In[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (H2L_Sig[2]) h2l_n++;
            if (Edge_Sig[2]) edge_n++;
        end
        checks++; if (h2l_n != 1) $display("FAIL mask_h2l got=%0d exp=1", h2l_n); else passes++;
        checks++; if (edge_n != 0) $display("FAIL mask_fall_edge got=%0d exp=0", edge_n); else passes++;
        checks++; if (Pending[2] !== 1'b0) $display("FAIL mask_fall_pending got=%b exp=0", Pending[2]); else passes++;
        Pin_In[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (Edge_Sig[2]) edge_n++;
        end
        checks++; if (edge_n != 1) $display("FAIL mask_rise_edge got=%0d exp=1", edge_n); else passes++;
        checks++; if (Pending[2] !== 1'b1) $display("FAIL mask_rise_pending got=%b exp=1", Pending[2]); else passes++;
        settle_and_clear();
        Edge_Mode = 8'b0000_0000;
        edge_n = 0;
        Pin_In[2] = 1'b0;
        repeat (10) @(negedge CLK) if (Edge_Sig[2]) edge_n++;
        Pin_In[2] = 1'b1;
        repeat (10) @(negedge CLK) if (Edge_Sig[2]) edge_n++;
        checks++; if (edge_n != 0) $display("FAIL mask_off_edge got=%0d exp=0", edge_n); else passes++;
        checks++; if (Pending[2] !== 1'b0) $display("FAIL mask_off_pending got=%b exp=0", Pending[2]); else passes++;
        settle_and_clear();
    endtask

    task automatic test_overrun();
        bit found = 0;
        Edge_Mode = 8'b1100_0000;
        Pin_In[3] = 1'b0;
        repeat (10) @(negedge CLK);
        Pin_In[3] = 1'b1;
        repeat (10) @(negedge CLK);
        checks++; if (Pending[3] !== 1'b1) $display("FAIL ovr_pending got=%b exp=1", Pending[3]); else passes++;
        checks++; if (Overrun[3] !== 1'b1) $display("FAIL ovr_overrun got=%b exp=1", Overrun[3]); else passes++;
        Clr_Pending[3] = 1'b1;
        @(negedge CLK);
        Clr_Pending[3] = 1'b0;
        checks++; if (Pending[3] !== 1'b0) $display("FAIL clr_pending got=%b exp=0", Pending[3]); else passes++;
        checks++; if (Overrun[3] !== 1'b0) $display("FAIL clr_overrun got=%b exp=0", Overrun[3]); else passes++;
        Pin_In[3] = 1'b0;
        repeat (10) @(negedge CLK);
        checks++; if ({Pending[3], Overrun[3]} !== 2'b10) $display("FAIL ovr_single got=%b exp=10", {Pending[3], Overrun[3]}); else passes++;
        Pin_In[3] = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge CLK);
            if (Edge_Sig[3]) begin
                Clr_Pending[3] = 1'b1;
                @(negedge CLK);
                Clr_Pending[3] = 1'b0;
                found = 1;
            end
        end
        checks++; if (!found) $display("FAIL clr_race_edge got=none exp=pulse within 20 cycles"); else passes++;
        checks++; if (Pending[3] !== 1'b1) $display("FAIL clr_race_pending got=%b exp=1", Pending[3]); else passes++;
        checks++; if (Overrun[3] !== 1'b0) $display("FAIL clr_race_overrun got=%b exp=0", Overrun[3]); else passes++;
        settle_and_clear();
    endtask

    task automatic test_reset_mid_filter();
        int early = 0, t_h2l = -1;
        Edge_Mode = 8'b0000_0001;
        Pin_In[0] = 1'b0;
        repeat (3) @(negedge CLK) if (H2L_Sig[0]) early++;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++; if (early != 0) $display("FAIL midrst_early got=%0d exp=0", early); else passes++;
        checks++; if (Level_Out[0] !== 1'b1) $display("FAIL midrst_level got=%b exp=1", Level_Out[0]); else passes++;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (H2L_Sig[0]) t_h2l = k;
        end
        checks++; if (t_h2l != 5) $display("FAIL midrst_h2l_edge got=%0d exp=5", t_h2l); else passes++;
        settle_and_clear();
    endtask

    task automatic test_random();
        int            hold[CH];
        logic [CH-1:0] eh, el, ee;
        for (int c = 0; c < CH; c++) hold[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK);
            eh = m_fd & ~m_f;
            el = ~m_fd & m_f;
            for (int c = 0; c < CH; c++) ee[c] = (Edge_Mode[2*c] & eh[c]) | (Edge_Mode[2*c+1] & el[c]);
            checks++; if (Level_Out !== m_f) $display("FAIL rnd_level cyc=%0d got=%h exp=%h", n, Level_Out, m_f); else passes++;
            checks++; if (H2L_Sig !== eh) $display("FAIL rnd_h2l cyc=%0d got=%h exp=%h", n, H2L_Sig, eh); else passes++;
            checks++; if (L2H_Sig !== el) $display("FAIL rnd_l2h cyc=%0d got=%h exp=%h", n, L2H_Sig, el); else passes++;
            checks++; if (Edge_Sig !== ee) $display("FAIL rnd_edge cyc=%0d got=%h exp=%h", n, Edge_Sig, ee); else passes++;
            checks++; if (Pending !== m_pend) $display("FAIL rnd_pending cyc=%0d got=%h exp=%h", n, Pending, m_pend); else passes++;
            checks++; if (Overrun !== m_ovr) $display("FAIL rnd_overrun cyc=%0d got=%h exp=%h", n, Overrun, m_ovr); else passes++;
            checks++; if (Any_Pending !== (|m_pend)) $display("FAIL rnd_any cyc=%0d got=%b exp=%b", n, Any_Pending, |m_pend); else passes++;
            RST = ($urandom_range(0, 299) == 0);
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    Pin_In[c] = 1'($urandom_range(0, 1));
                    hold[c]   = $urandom_range(1, 7);
                end else begin
                    hold[c]--;
                end
                Clr_Pending[c] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 49) == 0) Edge_Mode = 8'($urandom);
        end
        RST = 1'b0;
        Clr_Pending = '0;
        settle_and_clear();
    endtask

    initial begin
        test_reset();
        test_falling_edge();
        test_glitch();
        test_mode_mask();
        test_overrun();
        test_reset_mid_filter();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multi_edge_detect_module.md
# multi_edge_detect_module

Parametrised multi-channel edge detector: the successor of the single-line falling-edge detector used on the PS/2 and UART receive pins. Each channel gets a configurable-depth synchroniser, a glitch filter that accepts a new level only after it has been stable for `FILT_LEN` cycles, and per-channel edge selection (rising, falling, both or none). Selected edges set sticky pending flags with overrun tracking, so slow consumers do not lose events. It sits between the raw external pins and the receive state machines.

## Interface

**Parameters**
- `CH`, default 4: number of independent channels, at least 1.
- `SYNC_STAGES`, default 2: synchroniser flops per channel, at least 2.
- `FILT_LEN`, default 4: consecutive synchronised cycles a new level must persist before it is accepted, at least 1. A value of 1 means no filtering. The counter width is clog2(FILT_LEN), with a minimum of 1 bit.
- `INIT_LEVEL`, default 1'b1: reset value of every sync flop and filtered level. The default is idle-high, as for PS/2 and UART.

**Ports**
- `CLK` input, 1 bit: system clock; all state updates on the rising edge.
- `RST` input, 1 bit: synchronous, active-high reset.
- `Pin_In` input, CH bits: raw asynchronous pin levels.
- `Edge_Mode` input, 2*CH bits: per-channel select, with bits [2i+1:2i] belonging to channel i.
  - 00: off.
  - 01: falling edges only.
  - 10: rising edges only.
  - 11: both edges.
- `Clr_Pending` input, CH bits: per-channel clear of `Pending` and `Overrun`.
- `Level_Out` output, CH bits: filtered, synchronised level.
- `H2L_Sig` output, CH bits: one-cycle pulse for a filtered high-to-low transition; ignores the mode.
- `L2H_Sig` output, CH bits: one-cycle pulse for a filtered low-to-high transition; ignores the mode.
- `Edge_Sig` output, CH bits: `H2L_Sig`/`L2H_Sig` masked by `Edge_Mode`.
- `Pending` output, CH bits: sticky flag, set by `Edge_Sig`.
- `Overrun` output, CH bits: sticky flag, set by `Edge_Sig` while `Pending` is already 1.
- `Any_Pending` output, 1 bit: OR reduction of `Pending`.

## Operation

Each channel runs independently.

**Synchroniser**
- `sync[0]` <= `Pin_In`[i], and `sync[k]` <= `sync[k-1]`.
- `s` = `sync[SYNC_STAGES-1]`.

**Filter** (registers `f` = `Level_Out`[i] and `cnt`):
- If `s` == `f`: `cnt` <= 0.
- If `s` != `f` and `cnt` == FILT_LEN-1: `f` <= `s`, `cnt` <= 0.
- If `s` != `f` otherwise: `cnt` <= `cnt`+1.
- Any return of `s` to `f` before acceptance discards the count. A pulse shorter than FILT_LEN synchronised cycles never reaches `f`.

**Edge pulses**
- `f_d` <= `f` each cycle.
- `H2L_Sig` = `f_d` & ~`f`.
- `L2H_Sig` = ~`f_d` & `f`.
- Both are driven combinationally from registers only (glitch-free) and are each exactly one cycle wide.

**Mode**
- `Edge_Sig` = (mode[0] & `H2L_Sig`) | (mode[1] & `L2H_Sig`).
- A change of `Edge_Mode` applies in the same cycle; there is no retroactive reporting.

**Pending and Overrun**
- `Pending` <= `Edge_Sig` | (`Pending` & ~`Clr_Pending`).
- `Overrun` <= (`Edge_Sig` & `Pending` & ~`Clr_Pending`) | (`Overrun` & ~`Clr_Pending`).
- If a clear and an edge occur in the same cycle, the edge wins: `Pending` = 1 and `Overrun` = 0.

**Reset**
- At the next `CLK` edge with `RST` = 1: every sync flop, `f` and `f_d` go to `INIT_LEVEL`; `cnt`, `Pending` and `Overrun` go to 0.
- All pulse outputs are 0 while in reset; `Level_Out` = `INIT_LEVEL`.
- A reset in the middle of filtering discards the partial count.
- If a pin differs from `INIT_LEVEL` after reset, the transition is reported normally after the standard latency.

## Timing

- Edge 0 is the first `CLK` edge that samples a new, stable `Pin_In` value.
- `f` updates at edge SYNC_STAGES+FILT_LEN-1.
- The `H2L`/`L2H`/`Edge_Sig` pulse is high in the following cycle.
- `Pending` rises at edge SYNC_STAGES+FILT_LEN.
- With the defaults: `f` changes at edge 5, the pulse is seen by the consumer at edge 6, and `Pending` is 1 after edge 6.
- Minimum spacing between reported edges on one channel is FILT_LEN cycles.
- Channels never interact. `Clr_Pending` acts on the edge where it is sampled high.

## Test plan

1. **Reset:** hold `RST` for 3 cycles with `Pin_In`=4'hF. Then `Level_Out`=4'hF, all pulses 0, `Pending`=0, `Overrun`=0, `Any_Pending`=0.
2. **Falling edge, defaults:** `Edge_Mode`[1:0]=01; ch0 goes 1→0 and is held. `f` changes at edge 5. `H2L_Sig`[0] and `Edge_Sig`[0] are high for exactly one cycle. `Pending`[0]=1 from edge 6. `L2H_Sig`[0] is never asserted.
3. **Glitch rejection:** ch1 low for 3 cycles, then high. No pulse and `Level_Out`[1] stays 1. Repeat with a 4-cycle low: `H2L` then `L2H` pulses, 4 cycles apart.
4. **Mode masking:** ch2 mode=10, toggled 1→0→1 with 10-cycle holds. `H2L_Sig`[2] pulses but `Edge_Sig`[2] does not. Only the rising edge sets `Pending`[2]. Mode=00 sets nothing.
5. **Overrun and clear:** ch3 mode=11; two edges with no clear give `Pending`=1 and `Overrun`=1. `Clr_Pending`[3] for one cycle gives both 0. A clear in the same cycle as an `Edge_Sig` leaves `Pending`=1 and `Overrun`=0.
6. **Reset mid-filter:** pin goes low and `RST` pulses at edge 3. There is no pulse before reset. After reset the pin is still low, so `H2L_Sig` appears 6 edges after reset release.
